// File: rtl/param_gshare_predictor.sv
// Parameterised gshare/bimodal branch predictor: PHT of saturating counters,
// speculative global history with mispredict repair, and a mispredict counter.
module param_gshare_predictor #(
  parameter int IDX_W     = 7,
  parameter int CTR_W     = 2,
  parameter int HASH_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             predict_valid,
  input  logic [IDX_W-1:0] predict_pc,
  output logic             predict_taken,
  output logic [IDX_W-1:0] predict_history,
  input  logic             train_valid,
  input  logic             train_taken,
  input  logic             train_mispredicted,
  input  logic [IDX_W-1:0] train_history,
  input  logic [IDX_W-1:0] train_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int               PHT_N    = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  // Weakly not-taken: all ones shifted right gives 0..011, and 0 for CTR_W=1.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  function automatic logic [CTR_W-1:0] ctr_update(input logic [CTR_W-1:0] ctr,
                                                  input logic             taken);
    logic [CTR_W-1:0] res;
    if (taken) begin
      if (ctr == CTR_MAX) res = ctr;
      else                res = ctr + CTR_ONE;
    end else begin
      if (ctr == CTR_ZERO) res = ctr;
      else                 res = ctr - CTR_ONE;
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] pht_index(input logic [IDX_W-1:0] pc,
                                                 input logic [IDX_W-1:0] hist);
    logic [IDX_W-1:0] idx;
    if (HASH_MODE == 1) idx = pc;
    else                idx = pc ^ hist;
    return idx;
  endfunction

  logic [CTR_W-1:0] pht_r [PHT_N];
  logic [IDX_W-1:0] ghr_r;
  logic [CNT_W-1:0] cnt_r;

  logic [IDX_W-1:0] pred_idx_s;
  logic [IDX_W-1:0] train_idx_s;
  logic [CTR_W-1:0] pred_ctr_s;
  logic [IDX_W-1:0] ghr_next_s;
  logic             train_mis_s;

  // Index generation and combinational prediction from the current state.
  always_comb begin
    pred_idx_s      = pht_index(predict_pc, ghr_r);
    train_idx_s     = pht_index(train_pc, train_history);
    pred_ctr_s      = pht_r[pred_idx_s];
    predict_taken   = pred_ctr_s[CTR_W-1];
    predict_history = ghr_r;
    train_mis_s     = train_valid & train_mispredicted;
  end

  // History next-state: mispredict repair beats the speculative shift.
  always_comb begin
    ghr_next_s = ghr_r;
    if (train_mis_s) begin
      ghr_next_s = {train_history[IDX_W-2:0], train_taken};
    end else if (predict_valid) begin
      ghr_next_s = {ghr_r[IDX_W-2:0], predict_taken};
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (areset) ghr_r <= IDX_ZERO;
    else        ghr_r <= ghr_next_s;
  end

  // Pattern history table; the whole array is flop-based so reset takes one cycle.
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < PHT_N; i++) pht_r[i] <= CTR_INIT;
    end else if (train_valid) begin
      pht_r[train_idx_s] <= ctr_update(pht_r[train_idx_s], train_taken);
    end
  end

  // Saturating mispredict statistics counter.
  always_ff @(posedge clk) begin
    if (areset)                             cnt_r <= CNT_ZERO;
    else if (train_mis_s && cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
  end

  assign mispredict_count = cnt_r;

endmodule

// File: tb/tb_param_gshare_predictor.sv
// Directed bench for param_gshare_predictor: default gshare, small stats
// counter, and a bimodal 4-bit/3-bit-counter configuration.
module tb_param_gshare_predictor;

  logic clk = 1'b0;
  logic areset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Default configuration
  logic       d_pv, d_pt, d_tv, d_tt, d_tm;
  logic [6:0] d_pc, d_ph, d_th, d_tpc;
  logic [15:0] d_cnt;

  // CNT_W = 2
  logic       c_pv, c_pt, c_tv, c_tt, c_tm;
  logic [6:0] c_pc, c_ph, c_th, c_tpc;
  logic [1:0] c_cnt;

  // Bimodal, IDX_W = 4, CTR_W = 3
  logic       b_pv, b_pt, b_tv, b_tt, b_tm;
  logic [3:0] b_pc, b_ph, b_th, b_tpc;
  logic [15:0] b_cnt;

  param_gshare_predictor u_dut (
    .clk(clk), .areset(areset),
    .predict_valid(d_pv), .predict_pc(d_pc),
    .predict_taken(d_pt), .predict_history(d_ph),
    .train_valid(d_tv), .train_taken(d_tt), .train_mispredicted(d_tm),
    .train_history(d_th), .train_pc(d_tpc), .mispredict_count(d_cnt)
  );

  param_gshare_predictor #(.CNT_W(2)) u_cnt (
    .clk(clk), .areset(areset),
    .predict_valid(c_pv), .predict_pc(c_pc),
    .predict_taken(c_pt), .predict_history(c_ph),
    .train_valid(c_tv), .train_taken(c_tt), .train_mispredicted(c_tm),
    .train_history(c_th), .train_pc(c_tpc), .mispredict_count(c_cnt)
  );

  param_gshare_predictor #(.IDX_W(4), .CTR_W(3), .HASH_MODE(1)) u_bim (
    .clk(clk), .areset(areset),
    .predict_valid(b_pv), .predict_pc(b_pc),
    .predict_taken(b_pt), .predict_history(b_ph),
    .train_valid(b_tv), .train_taken(b_tt), .train_mispredicted(b_tm),
    .train_history(b_th), .train_pc(b_tpc), .mispredict_count(b_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    d_pv = 1'b0; d_pc = 7'h00; d_tv = 1'b0; d_tt = 1'b0; d_tm = 1'b0; d_th = 7'h00; d_tpc = 7'h00;
    c_pv = 1'b0; c_pc = 7'h00; c_tv = 1'b0; c_tt = 1'b0; c_tm = 1'b0; c_th = 7'h00; c_tpc = 7'h00;
    b_pv = 1'b0; b_pc = 4'h0;  b_tv = 1'b0; b_tt = 1'b0; b_tm = 1'b0; b_th = 4'h0;  b_tpc = 4'h0;
  endtask

  task automatic do_reset;
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  task automatic d_train(input logic [6:0] pc, input logic [6:0] hist, input logic taken,
                         input logic mis);
    d_tv = 1'b1; d_tpc = pc; d_th = hist; d_tt = taken; d_tm = mis;
    tick();
    d_tv = 1'b0; d_tt = 1'b0; d_tm = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] pcs [5];
    pcs[0] = 7'h00; pcs[1] = 7'h03; pcs[2] = 7'h05; pcs[3] = 7'h7F; pcs[4] = 7'h2A;
    idle_all();
    // Reset must override simultaneous predict and mispredict-train activity.
    d_pv = 1'b1; d_pc = 7'h40; d_tv = 1'b1; d_tm = 1'b1; d_tt = 1'b1; d_th = 7'h7F; d_tpc = 7'h03;
    do_reset();
    idle_all();
    #1;
    checks++; if (d_ph !== 7'h00) begin errors++; $display("FAIL reset_history: got %h want 00", d_ph); end
    checks++; if (d_cnt !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", d_cnt); end
    for (int i = 0; i < 5; i++) begin
      d_pc = pcs[i];
      #1;
      checks++; if (d_pt !== 1'b0) begin errors++; $display("FAIL reset_taken pc=%h: got %b want 0", pcs[i], d_pt); end
    end
    tick();
    d_pv = 1'b1; d_pc = 7'h05;
    #1;
    checks++; if (d_pt !== 1'b0) begin errors++; $display("FAIL pred_pc05_taken: got %b want 0", d_pt); end
    checks++; if (d_ph !== 7'h00) begin errors++; $display("FAIL pred_pc05_history: got %h want 00", d_ph); end
    tick();
    d_pv = 1'b0;
    #1;
    checks++; if (d_ph !== 7'h00) begin errors++; $display("FAIL pred_shift0_history: got %h want 00", d_ph); end
  endtask

  task automatic test_counter_saturation;
    idle_all();
    do_reset();
    d_pc = 7'h03;
    d_train(7'h03, 7'h00, 1'b1, 1'b0);  // 01 -> 10
    #1;
    checks++; if (d_pt !== 1'b1) begin errors++; $display("FAIL ctr_10: got %b want 1", d_pt); end
    d_train(7'h03, 7'h00, 1'b1, 1'b0);  // 10 -> 11
    #1;
    checks++; if (d_pt !== 1'b1) begin errors++; $display("FAIL ctr_11: got %b want 1", d_pt); end
    d_train(7'h03, 7'h00, 1'b1, 1'b0);  // stays 11
    d_train(7'h03, 7'h00, 1'b0, 1'b0);  // 10
    #1;
    checks++; if (d_pt !== 1'b1) begin errors++; $display("FAIL ctr_sat_hi_10: got %b want 1", d_pt); end
    d_train(7'h03, 7'h00, 1'b0, 1'b0);  // 01
    #1;
    checks++; if (d_pt !== 1'b0) begin errors++; $display("FAIL ctr_sat_hi_01: got %b want 0", d_pt); end
    d_train(7'h03, 7'h00, 1'b0, 1'b0);  // 00
    d_train(7'h03, 7'h00, 1'b0, 1'b0);  // stays 00
    // Fields with train_valid low must not touch PHT, GHR or the counter.
    d_tv = 1'b0; d_tpc = 7'h03; d_tt = 1'b1; d_tm = 1'b1; d_th = 7'h55;
    tick(); tick();
    d_tt = 1'b0; d_tm = 1'b0;
    d_train(7'h03, 7'h00, 1'b1, 1'b0);  // 01
    d_train(7'h03, 7'h00, 1'b1, 1'b0);  // 10
    #1;
    checks++; if (d_pt !== 1'b1) begin errors++; $display("FAIL ctr_sat_lo_10: got %b want 1", d_pt); end
    checks++; if (d_ph !== 7'h00) begin errors++; $display("FAIL train_no_ghr: got %h want 00", d_ph); end
    checks++; if (d_cnt !== 16'h0000) begin errors++; $display("FAIL train_no_count: got %h want 0000", d_cnt); end
  endtask

  task automatic test_ghr_repair;
    logic [6:0] pcs [5];
    logic       exp_t [5];
    logic [6:0] exp_h [5];
    pcs[0] = 7'h40; exp_t[0] = 1'b1; exp_h[0] = 7'h00;
    pcs[1] = 7'h00; exp_t[1] = 1'b0; exp_h[1] = 7'h01;
    pcs[2] = 7'h42; exp_t[2] = 1'b1; exp_h[2] = 7'h02;
    pcs[3] = 7'h00; exp_t[3] = 1'b0; exp_h[3] = 7'h05;
    pcs[4] = 7'h4A; exp_t[4] = 1'b1; exp_h[4] = 7'h0A;
    idle_all();
    do_reset();
    d_train(7'h40, 7'h00, 1'b1, 1'b0);  // entry 0x40 -> 10 (taken)
    for (int i = 0; i < 5; i++) begin
      d_pv = 1'b1; d_pc = pcs[i];
      #1;
      checks++; if (d_pt !== exp_t[i]) begin errors++; $display("FAIL spec_taken step%0d: got %b want %b", i, d_pt, exp_t[i]); end
      checks++; if (d_ph !== exp_h[i]) begin errors++; $display("FAIL spec_history step%0d: got %h want %h", i, d_ph, exp_h[i]); end
      tick();
    end
    d_pv = 1'b0;
    #1;
    checks++; if (d_ph !== 7'h15) begin errors++; $display("FAIL ghr_built: got %h want 15", d_ph); end
    // Predict would shift in a taken bit; the mispredict repair must win.
    d_pv = 1'b1; d_pc = 7'h55;
    d_tv = 1'b1; d_tm = 1'b1; d_tt = 1'b1; d_th = 7'h2A; d_tpc = 7'h01;
    tick();
    idle_all();
    #1;
    checks++; if (d_ph !== 7'h55) begin errors++; $display("FAIL repair_priority: got %h want 55", d_ph); end
    checks++; if (d_cnt !== 16'h0001) begin errors++; $display("FAIL repair_count: got %h want 0001", d_cnt); end
    d_train(7'h10, 7'h7F, 1'b0, 1'b1);
    #1;
    checks++; if (d_ph !== 7'h7E) begin errors++; $display("FAIL repair_not_taken: got %h want 7E", d_ph); end
    checks++; if (d_cnt !== 16'h0002) begin errors++; $display("FAIL repair_count2: got %h want 0002", d_cnt); end
  endtask

  task automatic test_same_index;
    idle_all();
    do_reset();
    d_pv = 1'b1; d_pc = 7'h20;
    d_tv = 1'b1; d_tpc = 7'h20; d_th = 7'h00; d_tt = 1'b1; d_tm = 1'b0;
    #1;
    checks++; if (d_pt !== 1'b0) begin errors++; $display("FAIL same_idx_now: got %b want 0", d_pt); end
    tick();
    idle_all();
    d_pc = 7'h20;
    #1;
    checks++; if (d_pt !== 1'b1) begin errors++; $display("FAIL same_idx_next: got %b want 1", d_pt); end
  endtask

  task automatic test_mispredict_count;
    logic [1:0] exp;
    idle_all();
    do_reset();
    #1;
    checks++; if (c_cnt !== 2'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", c_cnt); end
    for (int i = 0; i < 5; i++) begin
      c_tv = 1'b1; c_tm = 1'b1; c_tt = 1'b0; c_tpc = 7'(i);
      tick();
      c_tv = 1'b0; c_tm = 1'b0;
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      #1;
      checks++; if (c_cnt !== exp) begin errors++; $display("FAIL cnt_step%0d: got %0d want %0d", i, c_cnt, exp); end
    end
    c_tv = 1'b1; c_tm = 1'b1;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    c_tv = 1'b0; c_tm = 1'b0;
    #1;
    checks++; if (c_cnt !== 2'd0) begin errors++; $display("FAIL cnt_mid_reset: got %0d want 0", c_cnt); end
    c_tv = 1'b1; c_tm = 1'b1;
    tick();
    c_tm = 1'b0;
    tick();
    c_tv = 1'b0;
    #1;
    checks++; if (c_cnt !== 2'd1) begin errors++; $display("FAIL cnt_after_reset: got %0d want 1", c_cnt); end
  endtask

  task automatic test_bimodal;
    idle_all();
    do_reset();
    b_pc = 4'h9;
    #1;
    checks++; if (b_pt !== 1'b0) begin errors++; $display("FAIL bim_reset_taken: got %b want 0", b_pt); end
    b_tv = 1'b1; b_tpc = 4'h9; b_th = 4'h5; b_tt = 1'b1; b_tm = 1'b0;
    tick();
    b_tv = 1'b0;
    #1;
    checks++; if (b_pt !== 1'b1) begin errors++; $display("FAIL bim_3to4: got %b want 1", b_pt); end
    b_tv = 1'b1; b_th = 4'hA; b_tt = 1'b0;
    tick();
    b_tv = 1'b0;
    #1;
    checks++; if (b_pt !== 1'b0) begin errors++; $display("FAIL bim_4to3: got %b want 0", b_pt); end
    b_tv = 1'b1; b_th = 4'h3; b_tt = 1'b1; b_tm = 1'b1;
    tick();
    b_tv = 1'b0; b_tm = 1'b0;
    #1;
    checks++; if (b_ph !== 4'h7) begin errors++; $display("FAIL bim_ghr: got %h want 7", b_ph); end
    checks++; if (b_pt !== 1'b1) begin errors++; $display("FAIL bim_pred_ghr7: got %b want 1", b_pt); end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_counter_saturation();
    test_ghr_repair();
    test_same_index();
    test_mispredict_count();
    test_bimodal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_gshare_predictor.md
PARAM_GSHARE_PREDICTOR -- requirements
Module: param_gshare_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 7: width of PC, global history and pattern-history-table (PHT) index; legal range 2..12.
REQ-002 SHALL have parameter CTR_W, default 2: saturating-counter width per PHT entry; legal range 1..4.
REQ-003 SHALL have parameter HASH_MODE, default 0: 0 = gshare (index = pc XOR history), 1 = bimodal (index = pc; history still tracked).
REQ-004 SHALL have parameter CNT_W, default 16: mispredict statistics counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 areset  input  1  reset, synchronous, active-high.
REQ-007 predict_valid  input  1  prediction request this cycle.
REQ-008 predict_pc  input  IDX_W  PC of branch being predicted.
REQ-009 predict_taken  output  1  prediction, combinational from current state.
REQ-010 predict_history  output  IDX_W  global history used for this prediction, combinational.
REQ-011 train_valid  input  1  training update this cycle.
REQ-012 train_taken  input  1  actual branch outcome.
REQ-013 train_mispredicted  input  1  branch was mispredicted.
REQ-014 train_history  input  IDX_W  history returned with the original prediction.
REQ-015 train_pc  input  IDX_W  PC of branch being trained.
REQ-016 mispredict_count  output  CNT_W  saturating count of trained mispredictions.

Function
REQ-017 SHALL hold a PHT of 2^IDX_W entries of CTR_W-bit unsigned counters and an IDX_W-bit global history register (GHR).
REQ-018 Predict index SHALL be predict_pc XOR GHR (HASH_MODE 0) or predict_pc (HASH_MODE 1); predict_taken SHALL be the MSB of that PHT entry.
REQ-019 predict_history SHALL equal the GHR value before this cycle's edge; outputs are valid regardless of predict_valid.
REQ-020 On predict_valid without a mispredict-train, GHR SHALL become {GHR[IDX_W-2:0], predict_taken} at the next edge (speculative update).
REQ-021 Train index SHALL be train_pc XOR train_history (HASH_MODE 0) or train_pc (HASH_MODE 1), never the live GHR.
REQ-022 On train_valid, the indexed counter SHALL increment if train_taken, else decrement, saturating at 2^CTR_W-1 and 0.
REQ-023 On train_valid with train_mispredicted, GHR SHALL become {train_history[IDX_W-2:0], train_taken}; this SHALL take priority over any same-cycle predict update.
REQ-024 train_valid with train_mispredicted=0 SHALL NOT modify GHR.
REQ-025 Same-cycle predict and train to the same index: predict_taken SHALL reflect the pre-update counter (PHT write visible next cycle).
REQ-026 mispredict_count SHALL increment by 1 on each cycle with train_valid and train_mispredicted, saturating at 2^CNT_W-1.
REQ-027 train_taken, train_mispredicted, train_history and train_pc SHALL be ignored when train_valid=0.

Reset
REQ-028 With areset high at an edge: GHR SHALL become 0, every PHT entry 2^(CTR_W-1)-1 (weakly not-taken; 0 for CTR_W=1), and mispredict_count 0.
REQ-029 areset SHALL override any same-cycle predict or train; after release, predict_taken SHALL be 0 for all PCs (CTR_W>=2) and predict_history 0.
REQ-030 Reset SHALL complete in one cycle; no multi-cycle array initialisation.

Verification
REQ-031 Reset, then predict_valid with pc=0x05 -> predict_taken=0, predict_history=0x00; next cycle predict_history=0x00 (shifted-in 0).
REQ-032 Defaults; train pc=0x03, history=0x00, taken=1 twice -> entry 3 goes 01->10->11; predict pc=0x03 with GHR=0 -> predict_taken=1; four not-taken trains -> saturates at 00.
REQ-033 GHR=0x15 from predicts; same cycle predict_valid and train mispredicted history=0x2A, taken=1 -> next GHR=0x55 (train wins).
REQ-034 Same-cycle train taken and predict on same index at counter 01 -> predict_taken=0 that cycle, 1 the next.
REQ-035 CNT_W=2: five mispredict trains -> mispredict_count 1,2,3,3,3; areset mid-sequence -> 0 next cycle.
REQ-036 HASH_MODE=1, IDX_W=4, CTR_W=3: reset counters = 3; train pc=0x9 taken with differing train_history -> same entry updated (3->4), predict pc=0x9 -> taken=1.
